// File: rtl/execute_pipe.sv
// execute_pipe
//   Registered execute stage between decode and memory. Single-cycle ALU ops
//   (add, logic, shifts, rotates, pass-B), branch/jump resolution producing the
//   next PC, and an iterative radix-2 shift-add multiply taking WIDTH+1 cycles.
//   Valid/ready handshakes on both sides; flush squashes in-flight work.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   flush                   squash the running MUL and the held output
//   in_valid / in_ready     upstream handshake
//   op                      0 ADD,1 AND,2 OR,3 XOR,4 SLL,5 SRL,6 ROL,7 ROR,8 MUL, else PASSB
//   in_a, in_b              operands; inv_a/inv_b select their complements
//   cin                     carry-in for ADD
//   brch_sig                0 none,1 BEQZ,2 BNEZ,3 BLTZ,4 BGEZ,5 JMP,6 JR,7 none
//   inc_pc, imm             PC+2 of this op and its sign-extended displacement
//   out_valid / out_ready   downstream handshake
//   alu_result, new_pc, taken  registered results
module execute_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    input  logic [2:0]       brch_sig,
    input  logic [WIDTH-1:0] inc_pc,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] new_pc,
    output logic             taken
);

    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   opa, opb;
    logic [WIDTH-1:0]   alu_out;
    logic [SHAMT_W-1:0] sh;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH:0]     br_now, br_mul;

    logic accept, accept_mul, accept_alu, mul_done;

    // Multiplier working registers plus the branch context of the MUL op,
    // which is only resolved once the product is known (JR uses it).
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_a, m_pc, m_imm;
    logic [2:0]       m_brch;

    // Returns {taken, next_pc}. Conditions look at the raw A operand, not A'.
    function automatic logic [WIDTH:0] resolve_branch(
        input logic [2:0]       brch,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] disp,
        input logic [WIDTH-1:0] res
    );
        logic             t;
        logic [WIDTH-1:0] target;
        target = pc + disp;
        case (brch)
            3'd1:    t = (a == '0);
            3'd2:    t = (a != '0);
            3'd3:    t = a[WIDTH-1];
            3'd4:    t = ~a[WIDTH-1];
            3'd5:    t = 1'b1;
            3'd6:    t = 1'b1;
            default: t = 1'b0;
        endcase
        if (brch == 3'd6) begin
            return {1'b1, res};
        end
        return {t, t ? target : pc};
    endfunction

    assign opa = inv_a ? ~in_a : in_a;
    assign opb = inv_b ? ~in_b : in_b;

    // Single-cycle ALU. Rotates come from shifting a doubled copy of A'.
    always_comb begin
        sh    = opb[SHAMT_W-1:0];
        rot_l = {opa, opa} << sh;
        rot_r = {opa, opa} >> sh;
        case (op)
            4'd0:    alu_out = opa + opb + {{(WIDTH-1){1'b0}}, cin};
            4'd1:    alu_out = opa & opb;
            4'd2:    alu_out = opa | opb;
            4'd3:    alu_out = opa ^ opb;
            4'd4:    alu_out = opa << sh;
            4'd5:    alu_out = opa >> sh;
            4'd6:    alu_out = rot_l[2*WIDTH-1:WIDTH];
            4'd7:    alu_out = rot_r[WIDTH-1:0];
            default: alu_out = opb;
        endcase
    end

    assign br_now = resolve_branch(brch_sig, in_a, inc_pc, imm, alu_out);
    assign br_mul = resolve_branch(m_brch, m_a, m_pc, m_imm, acc);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: flush aborts a running multiply.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept_mul) state_next = MUL_BUSY;
            MUL_BUSY: if (flush || mul_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs. A MUL only starts when the output register is free or being
    // drained this cycle, so its completion can never overwrite a live result.
    always_comb begin
        in_ready   = (state == IDLE) && !flush && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        accept_mul = accept && (op == OP_MUL);
        accept_alu = accept && (op != OP_MUL);
        mul_done   = (state == MUL_BUSY) && (cnt == CNT_DONE);
    end

    // Shift-add multiplier: WIDTH steps, then one more cycle to publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            m_a    <= '0;
            m_pc   <= '0;
            m_imm  <= '0;
            m_brch <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept_mul) begin
            mcand  <= opa;
            mplier <= opb;
            acc    <= '0;
            cnt    <= '0;
            m_a    <= in_a;
            m_pc   <= inc_pc;
            m_imm  <= imm;
            m_brch <= brch_sig;
        end else if (state == MUL_BUSY && !mul_done) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Output register: flush wins over everything, a fresh result wins over a
    // consume, and otherwise the output holds until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            new_pc     <= '0;
            taken      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_alu) begin
            out_valid  <= 1'b1;
            alu_result <= alu_out;
            new_pc     <= br_now[WIDTH-1:0];
            taken      <= br_now[WIDTH];
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            alu_result <= acc;
            new_pc     <= br_mul[WIDTH-1:0];
            taken      <= br_mul[WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe
//   Directed checks with hand-computed values followed by randomized traffic,
//   all compared every cycle against a behavioural model of the stage.
module tb_execute_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  in_a, in_b;
    logic          inv_a, inv_b, cin;
    logic [2:0]    brch_sig;
    logic [W-1:0]  inc_pc, imm;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_result, new_pc;
    logic          taken;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: the visible output register and a pending multiply.
    logic          mValid;
    logic [W-1:0]  mRes, mPc;
    logic          mTaken;
    int            mBusyLeft;
    logic [W-1:0]  pRes, pPc;
    logic          pTaken;

    execute_pipe #(.WIDTH(W), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in_a(in_a), .in_b(in_b),
        .inv_a(inv_a), .inv_b(inv_b), .cin(cin),
        .brch_sig(brch_sig), .inc_pc(inc_pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .new_pc(new_pc), .taken(taken)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic v, input logic [3:0] f_op, input logic [W-1:0] a, input logic [W-1:0] b,
        input logic ia, input logic ib, input logic ci, input logic [2:0] br,
        input logic [W-1:0] pc, input logic [W-1:0] im, input logic ordy, input logic fl
    );
        in_valid = v;  op = f_op;  in_a = a;  in_b = b;
        inv_a = ia;    inv_b = ib; cin = ci;  brch_sig = br;
        inc_pc = pc;   imm = im;   out_ready = ordy; flush = fl;
    endtask

    task automatic applyIdle(input logic ordy);
        applyStimulus(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, ordy, 1'b0);
    endtask

    // Inputs always change 2 time units after a rising edge.
    task automatic stepCycle;
        @(posedge clk);
        #2;
    endtask

    // Reference semantics written as plain arithmetic on integers.
    function automatic void refExec(
        input logic [3:0] f_op, input logic [W-1:0] a, input logic [W-1:0] b,
        input logic ia, input logic ib, input logic ci, input logic [2:0] br,
        input logic [W-1:0] pc, input logic [W-1:0] im,
        output logic [W-1:0] r, output logic [W-1:0] npc, output logic t
    );
        longint A, B, M, res, sh, tgt;
        logic [W-1:0] aa, bb;
        aa = ia ? ~a : a;
        bb = ib ? ~b : b;
        A = longint'(aa);
        B = longint'(bb);
        M = 65536;
        sh = B % 16;
        case (f_op)
            4'd0:    res = (A + B + longint'(ci)) % M;
            4'd1:    res = A & B;
            4'd2:    res = A | B;
            4'd3:    res = A ^ B;
            4'd4:    res = (A * (64'sd1 << sh)) % M;
            4'd5:    res = A / (64'sd1 << sh);
            4'd6:    res = (A * (64'sd1 << sh)) % M + A / (64'sd1 << (16 - sh));
            4'd7:    res = A / (64'sd1 << sh) + (A % (64'sd1 << sh)) * (64'sd1 << (16 - sh));
            4'd8:    res = (A * B) % M;
            default: res = B;
        endcase
        r = res[W-1:0];
        case (br)
            3'd1:    t = (a == 0);
            3'd2:    t = (a != 0);
            3'd3:    t = a[W-1];
            3'd4:    t = !a[W-1];
            3'd5:    t = 1'b1;
            3'd6:    t = 1'b1;
            default: t = 1'b0;
        endcase
        tgt = (longint'(pc) + longint'(im)) % M;
        if (br == 3'd6)  npc = r;
        else if (t)      npc = tgt[W-1:0];
        else             npc = pc;
    endfunction

    // Compare process: on every falling edge check the DUT against the model,
    // then advance the model to what the coming rising edge must produce.
    always @(negedge clk) begin
        logic expReady;
        logic [W-1:0] r, npc;
        logic t;
        if (!rst_n) begin
            checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("rst_alu_result", {16'b0, alu_result}, 32'd0);
            mValid = 1'b0; mRes = '0; mPc = '0; mTaken = 1'b0; mBusyLeft = 0;
        end else begin
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mValid});
            if (mValid) begin
                checkOutput("alu_result", {16'b0, alu_result}, {16'b0, mRes});
                checkOutput("new_pc", {16'b0, new_pc}, {16'b0, mPc});
                checkOutput("taken", {31'b0, taken}, {31'b0, mTaken});
            end
            expReady = (mBusyLeft == 0) && !flush && (!mValid || out_ready);
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
            if (flush) begin
                mValid = 1'b0;
                mBusyLeft = 0;
            end else if (mBusyLeft > 0) begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin
                    mValid = 1'b1; mRes = pRes; mPc = pPc; mTaken = pTaken;
                end
            end else begin
                if (mValid && out_ready) mValid = 1'b0;
                if (in_valid && expReady) begin
                    refExec(op, in_a, in_b, inv_a, inv_b, cin, brch_sig, inc_pc, imm, r, npc, t);
                    if (op == 4'd8) begin
                        mBusyLeft = W + 1;
                        pRes = r; pPc = npc; pTaken = t;
                    end else begin
                        mValid = 1'b1; mRes = r; mPc = npc; mTaken = t;
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [3:0]   rop;
        rst_n = 1'b0;
        applyIdle(1'b1);
        #1;
        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_pc", {16'b0, new_pc}, 32'd0);
        stepCycle;
        rst_n = 1'b1;

        // ADD with overflow into the sign bit.
        stepCycle;
        applyStimulus(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0100, 16'h0000, 1'b1, 1'b0);
        stepCycle;
        applyIdle(1'b1);
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_result", {16'b0, alu_result}, 32'h8000);
        checkOutput("add_pc", {16'b0, new_pc}, 32'h0100);

        // BEQZ taken with negative displacement, then not taken.
        stepCycle;
        applyStimulus(1'b1, 4'd0, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0040, 16'hFFF8, 1'b1, 1'b0);
        stepCycle;
        applyStimulus(1'b1, 4'd0, 16'h0001, 16'h0005, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0040, 16'hFFF8, 1'b1, 1'b0);
        checkOutput("beqz_taken", {31'b0, taken}, 32'd1);
        checkOutput("beqz_pc", {16'b0, new_pc}, 32'h0038);
        stepCycle;
        applyIdle(1'b1);
        checkOutput("beqz_nt_taken", {31'b0, taken}, 32'd0);
        checkOutput("beqz_nt_pc", {16'b0, new_pc}, 32'h0040);

        // Asynchronous reset in the middle of a cycle with a live output.
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_rst_result", {16'b0, alu_result}, 32'd0);
        checkOutput("async_rst_pc", {16'b0, new_pc}, 32'd0);
        checkOutput("async_rst_taken", {31'b0, taken}, 32'd0);
        stepCycle;
        rst_n = 1'b1;

        // MUL latency: accepted at edge N, result at edge N+17.
        stepCycle;
        applyStimulus(1'b1, 4'd8, 16'h0123, 16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0200, 16'h0000, 1'b0, 1'b0);
        stepCycle;
        applyIdle(1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("mul_busy_ready", {31'b0, in_ready}, 32'd0);
            stepCycle;
        end
        checkOutput("mul_not_early", {31'b0, out_valid}, 32'd0);
        stepCycle;
        checkOutput("mul_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("mul_result", {16'b0, alu_result}, 32'h1230);

        // Back-pressure: result held, nothing accepted, then released.
        applyStimulus(1'b1, 4'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0300, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("stall_result", {16'b0, alu_result}, 32'h1230);
            stepCycle;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_ready", {31'b0, in_ready}, 32'd1);
        stepCycle;
        applyIdle(1'b1);
        checkOutput("release_result", {16'b0, alu_result}, 32'h0002);

        // Flush while the multiplier is at count 7.
        stepCycle;
        applyStimulus(1'b1, 4'd8, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0400, 16'h0000, 1'b1, 1'b0);
        stepCycle;
        applyIdle(1'b1);
        repeat (7) stepCycle;
        applyStimulus(1'b1, 4'd0, 16'h0009, 16'h0009, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0500, 16'h0000, 1'b1, 1'b1);
        #1;
        checkOutput("flush_blocks_accept", {31'b0, in_ready}, 32'd0);
        stepCycle;
        applyStimulus(1'b1, 4'd0, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0600, 16'h0000, 1'b1, 1'b0);
        #1;
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
        stepCycle;
        applyIdle(1'b1);
        checkOutput("post_flush_add", {16'b0, alu_result}, 32'h0005);

        // Randomized traffic, including one reset pulse mid-stream.
        for (int i = 0; i < 3000; i++) begin
            stepCycle;
            if (i == 1500) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            ra  = ($urandom_range(0, 3) == 0) ? 16'h0000 : W'($urandom);
            rop = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 9) < 7, rop, ra, W'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                          W'($urandom), W'($urandom),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        stepCycle;
        rst_n = 1'b1;
        applyIdle(1'b1);
        repeat (20) stepCycle;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
